// File: rtl/ikbd_serial.sv
// Keyboard-side endpoint of the IKBD serial link.
// Both directions use 8N1 framing, LSB first, with 16x oversampling.
// The transmit side drains a small byte FIFO fed by the report logic.
//
// RX FSM
//   state  | meaning
//   IDLE   | line high, waiting for a low sample on a tick
//   START  | counting to mid start bit to reject false starts
//   DATA   | sampling 8 data bits at mid-bit
//   STOP   | sampling the stop bit
//   WAITHI | bad stop bit seen, waiting for the line to return high
//
// TX FSM
//   state  | meaning
//   IDLE   | line high, pops the FIFO on a tick when it is non-empty
//   START  | driving the start bit
//   DATA   | driving 8 data bits, LSB first
//   STOP   | driving the stop bit
module ikbd_serial #(
  parameter int TICK_DIV = 256,
  parameter int FIFO_AW  = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rx,
  output logic               tx,
  input  logic [7:0]         tx_data,
  input  logic               tx_wr,
  output logic               tx_full,
  output logic [FIFO_AW:0]   tx_level,
  output logic [7:0]         rx_data,
  output logic               rx_strobe,
  output logic               rx_frame_err,
  output logic               busy
);

  localparam int                 TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_LVL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  // ---------------------------------------------------------------- tick
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Free-running 1/16 bit-time prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // ---------------------------------------------------- rx conditioning
  logic [1:0] sync_q;
  logic [3:0] filt_sh_q;
  logic       filt_q;

  // Synchronise rx, then only follow it after four equal samples in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= 2'b11;
      filt_sh_q <= 4'hF;
      filt_q    <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx};
      filt_sh_q <= {filt_sh_q[2:0], sync_q[1]};
      if (&filt_sh_q)       filt_q <= 1'b1;
      else if (~|filt_sh_q) filt_q <= 1'b0;
    end
  end

  // ------------------------------------------------------------ rx fsm
  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_sub_q, rx_sub_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_strobe_q, rx_strobe_d;
  logic       rx_err_q, rx_err_d;

  // RX state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q  <= RX_IDLE;
      rx_sub_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_strobe_q <= 1'b0;
      rx_err_q    <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_sub_q    <= rx_sub_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_strobe_q <= rx_strobe_d;
      rx_err_q    <= rx_err_d;
    end
  end

  // RX next state: every timing step happens on a tick.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_sub_d    = rx_sub_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_strobe_d = 1'b0;
    rx_err_d    = rx_err_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (tick && !filt_q) begin
          rx_state_d = RX_START;
          rx_sub_d   = 4'd7;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_sub_q == 4'd0) begin
            if (filt_q) begin
              rx_state_d = RX_IDLE;
            end else begin
              rx_state_d = RX_DATA;
              rx_sub_d   = 4'd15;
              rx_bit_d   = 3'd0;
            end
          end else begin
            rx_sub_d = rx_sub_q - 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_sub_q == 4'd0) begin
            rx_shift_d = {filt_q, rx_shift_q[7:1]};
            rx_sub_d   = 4'd15;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_sub_d = rx_sub_q - 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_sub_q == 4'd0) begin
            if (filt_q) begin
              rx_data_d   = rx_shift_q;
              rx_strobe_d = 1'b1;
              rx_err_d    = 1'b0;
              rx_state_d  = RX_IDLE;
            end else begin
              rx_err_d   = 1'b1;
              rx_state_d = RX_WAITHI;
            end
          end else begin
            rx_sub_d = rx_sub_q - 4'd1;
          end
        end
      end
      RX_WAITHI: begin
        if (filt_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX outputs come straight from registers.
  always_comb begin
    rx_data      = rx_data_q;
    rx_strobe    = rx_strobe_q;
    rx_frame_err = rx_err_q;
  end

  // ----------------------------------------------------------- tx fifo
  logic [7:0]       fifo_mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic             push;
  logic             tx_pop;
  logic             fifo_empty;

  assign tx_level   = wr_ptr_q - rd_ptr_q;
  assign tx_full    = (tx_level == FULL_LVL);
  assign fifo_empty = (tx_level == '0);
  // Full is judged on the registered level, so a write while full is dropped
  // even if the transmitter pops on the same clock.
  assign push       = tx_wr && !tx_full;

  // FIFO storage; flushing is done by resetting the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= tx_data;
  end

  // FIFO pointers, wrapping naturally at 2^(FIFO_AW+1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tx_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ------------------------------------------------------------ tx fsm
  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_sub_q, tx_sub_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;

  // TX state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_sub_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sub_q   <= tx_sub_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // TX next state. STOP leaves one tick early: the IDLE tick that follows
  // still drives the line high, so the stop bit is a full 16 ticks on the
  // wire and back-to-back frames land exactly 160 ticks apart.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sub_d   = tx_sub_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_pop) begin
          tx_shift_d = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
          tx_state_d = TX_START;
          tx_sub_d   = 4'd15;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_sub_q == 4'd0) begin
            tx_state_d = TX_DATA;
            tx_sub_d   = 4'd15;
            tx_bit_d   = 3'd0;
          end else begin
            tx_sub_d = tx_sub_q - 4'd1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_sub_q == 4'd0) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            if (tx_bit_q == 3'd7) begin
              tx_state_d = TX_STOP;
              tx_sub_d   = 4'd14;
            end else begin
              tx_bit_d = tx_bit_q + 3'd1;
              tx_sub_d = 4'd15;
            end
          end else begin
            tx_sub_d = tx_sub_q - 4'd1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_sub_q == 4'd0) tx_state_d = TX_IDLE;
          else                  tx_sub_d   = tx_sub_q - 4'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX outputs: serial line level, FIFO pop and busy.
  always_comb begin
    tx     = 1'b1;
    tx_pop = 1'b0;
    case (tx_state_q)
      TX_IDLE:  tx_pop = tick && !fifo_empty;
      TX_START: tx     = 1'b0;
      TX_DATA:  tx     = tx_shift_q[0];
      TX_STOP:  tx     = 1'b1;
      default:  tx     = 1'b1;
    endcase
    busy = (tx_state_q != TX_IDLE) || !fifo_empty;
  end

endmodule

// File: tb/tb_ikbd_serial.sv
module tb_ikbd_serial;

  localparam int TICK_DIV = 4;
  localparam int FIFO_AW  = 3;
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int BIT_CLK  = 16 * TICK_DIV;

  logic               clk;
  logic               reset_n;
  logic               rx;
  logic               tx;
  logic [7:0]         tx_data;
  logic               tx_wr;
  logic               tx_full;
  logic [FIFO_AW:0]   tx_level;
  logic [7:0]         rx_data;
  logic               rx_strobe;
  logic               rx_frame_err;
  logic               busy;

  logic rx_drv;
  logic loop_en;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int strobe_cnt = 0;
  logic [7:0] strobe_data = 8'h00;

  // reference model state
  logic [7:0] txq [$];
  logic [7:0] last_rx;

  assign rx = loop_en ? tx : rx_drv;

  ikbd_serial #(.TICK_DIV(TICK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .tx           (tx),
    .tx_data      (tx_data),
    .tx_wr        (tx_wr),
    .tx_full      (tx_full),
    .tx_level     (tx_level),
    .rx_data      (rx_data),
    .rx_strobe    (rx_strobe),
    .rx_frame_err (rx_frame_err),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_strobe) begin
      strobe_cnt  = strobe_cnt + 1;
      strobe_data = rx_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Enqueue one byte; model accepts it only when fewer than DEPTH are queued.
  task automatic push(input logic [7:0] b);
    tx_data = b;
    tx_wr   = 1'b1;
    if (txq.size() < DEPTH) txq.push_back(b);
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic wait_fall(input string tag, output int t0);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    t0 = cyc;
    while (!ok && n < 2000) begin
      @(negedge clk);
      n++;
      if (tx === 1'b0) begin
        ok = 1'b1;
        t0 = cyc;
      end
    end
    check({tag, "_start_seen"}, {31'd0, ok}, 32'd1);
  endtask

  // Expected frame: start 0, data LSB first, stop 1, each bit BIT_CLK long.
  task automatic decode_from(input string tag, input int t0, input logic [7:0] exp_b);
    logic eb;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      eb = 1'b0;
      else if (k == 9) eb = 1'b1;
      else             eb = exp_b[k-1];
      wait_until(t0 + BIT_CLK * k + 20);
      check($sformatf("%s_b%0d_early", tag, k), {31'd0, tx}, {31'd0, eb});
      wait_until(t0 + BIT_CLK * k + 56);
      check($sformatf("%s_b%0d_late", tag, k), {31'd0, tx}, {31'd0, eb});
    end
  endtask

  // Drive one frame on rx; stop_low > 0 holds the stop bit low that many bits.
  task automatic send_rx(input logic [7:0] b, input int stop_low);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 9; k++) begin
      rx_drv = fr[k];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (stop_low > 0) begin
      rx_drv = 1'b0;
      repeat (BIT_CLK * stop_low) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (BIT_CLK * 2) @(negedge clk);
  endtask

  initial begin
    int t0, tprev, prev_cnt, lows;
    logic [7:0] b, cur;

    reset_n = 1'b0;
    rx_drv  = 1'b1;
    loop_en = 1'b0;
    tx_wr   = 1'b0;
    tx_data = 8'h00;
    last_rx = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_tx",       {31'd0, tx},           32'd1);
    check("rst_full",     {31'd0, tx_full},      32'd0);
    check("rst_level",    {28'd0, tx_level},     32'd0);
    check("rst_rx_data",  {24'd0, rx_data},      32'd0);
    check("rst_strobe",   {31'd0, rx_strobe},    32'd0);
    check("rst_err",      {31'd0, rx_frame_err}, 32'd0);
    check("rst_busy",     {31'd0, busy},         32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_tx", {31'd0, tx}, 32'd1);

    // ---- loopback: fixed 0xA5 then random bytes
    loop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      prev_cnt = strobe_cnt;
      push(b);
      wait_fall("lb", t0);
      cur = txq.pop_front();
      check("lb_busy", {31'd0, busy}, 32'd1);
      decode_from("lb", t0, cur);
      wait_until(t0 + 700);
      check("lb_strobe_cnt", strobe_cnt,            prev_cnt + 1);
      check("lb_strobe_data", {24'd0, strobe_data}, {24'd0, b});
      check("lb_rx_data",    {24'd0, rx_data},      {24'd0, b});
      check("lb_err",        {31'd0, rx_frame_err}, 32'd0);
      last_rx = b;
    end
    loop_en = 1'b0;
    repeat (20) @(negedge clk);

    // ---- burst: fill the FIFO while a leading frame is on the wire
    push(8'h55);
    wait_fall("burst_lead", t0);
    cur = txq.pop_front();
    for (int i = 1; i <= 9; i++) begin
      push(8'(i));
      if (i == 8) check("burst_full_8", {31'd0, tx_full}, (txq.size() == DEPTH) ? 32'd1 : 32'd0);
    end
    check("burst_level", {28'd0, tx_level}, txq.size());
    check("burst_full",  {31'd0, tx_full},  32'd1);
    decode_from("burst_lead", t0, cur);
    tprev = t0;
    for (int i = 0; i < DEPTH; i++) begin
      wait_fall("burst", t0);
      check("burst_spacing", t0 - tprev, 10 * BIT_CLK);
      cur = txq.pop_front();
      decode_from($sformatf("burst%0d", i), t0, cur);
      tprev = t0;
    end
    repeat (20) @(negedge clk);
    check("burst_busy_end",  {31'd0, busy},     32'd0);
    check("burst_level_end", {28'd0, tx_level}, 32'd0);

    // ---- simultaneous push and pop at level 3
    push(8'($urandom_range(0, 255)));
    wait_fall("sim_a", t0);
    cur = txq.pop_front();
    for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
    check("sim_level_pre", {28'd0, tx_level}, txq.size());
    decode_from("sim_a", t0, cur);
    wait_until(t0 + 10 * BIT_CLK - 1);
    b       = 8'($urandom_range(0, 255));
    tx_data = b;
    tx_wr   = 1'b1;
    txq.push_back(b);
    cur = txq.pop_front();
    @(negedge clk);
    tx_wr = 1'b0;
    check("sim_level_same", {28'd0, tx_level}, txq.size());
    check("sim_level_3",    {28'd0, tx_level}, 32'd3);
    check("sim_tx_started", {31'd0, tx},       32'd0);
    decode_from("sim_b", t0 + 10 * BIT_CLK, cur);
    for (int i = 0; i < 3; i++) begin
      wait_fall("sim_rest", t0);
      cur = txq.pop_front();
      decode_from($sformatf("sim_rest%0d", i), t0, cur);
    end
    repeat (20) @(negedge clk);
    check("sim_busy_end", {31'd0, busy}, 32'd0);

    // ---- receive: random bytes
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      prev_cnt = strobe_cnt;
      send_rx(b, 0);
      check("rx_cnt",  strobe_cnt,            prev_cnt + 1);
      check("rx_data", {24'd0, rx_data},      {24'd0, b});
      check("rx_err",  {31'd0, rx_frame_err}, 32'd0);
      last_rx = b;
    end

    // ---- framing error, then recovery
    prev_cnt = strobe_cnt;
    send_rx(8'h3C, 2);
    check("ferr_cnt",  strobe_cnt,            prev_cnt);
    check("ferr_err",  {31'd0, rx_frame_err}, 32'd1);
    check("ferr_keep", {24'd0, rx_data},      {24'd0, last_rx});
    send_rx(8'h80, 0);
    check("ferr_rec_cnt",  strobe_cnt,            prev_cnt + 1);
    check("ferr_rec_data", {24'd0, rx_data},      32'h80);
    check("ferr_rec_err",  {31'd0, rx_frame_err}, 32'd0);
    last_rx = 8'h80;

    // ---- glitch and false start
    prev_cnt = strobe_cnt;
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_cnt", strobe_cnt,            prev_cnt);
    check("glitch_err", {31'd0, rx_frame_err}, 32'd0);
    rx_drv = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * BIT_CLK) @(negedge clk);
    check("fstart_cnt",  strobe_cnt,            prev_cnt);
    check("fstart_err",  {31'd0, rx_frame_err}, 32'd0);
    check("fstart_data", {24'd0, rx_data},      {24'd0, last_rx});
    b = 8'($urandom_range(0, 255));
    send_rx(b, 0);
    check("fstart_after_cnt",  strobe_cnt,       prev_cnt + 1);
    check("fstart_after_data", {24'd0, rx_data}, {24'd0, b});

    // ---- reset mid-transmit
    push(8'hFF);
    wait_fall("rst_mid", t0);
    cur = txq.pop_front();
    push(8'h12);
    wait_until(t0 + BIT_CLK * 4 + 30);
    check("rst_mid_level_pre", {28'd0, tx_level}, txq.size());
    reset_n = 1'b0;
    #1;
    txq.delete();
    last_rx = 8'h00;
    check("rst_mid_tx",    {31'd0, tx},       32'd1);
    check("rst_mid_level", {28'd0, tx_level}, 32'd0);
    check("rst_mid_busy",  {31'd0, busy},     32'd0);
    check("rst_mid_rxd",   {24'd0, rx_data},  {24'd0, last_rx});
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rst_mid_no_residual", lows, 0);
    check("rst_mid_busy_after",  {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
